// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with enable, parallel load,
// wrap/saturate mode and registered one-cycle event pulses.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   en         in   count enable
//   up         in   1 = increment, 0 = decrement
//   load       in   parallel load request (beats en)
//   load_value in   value to load, clamped to MODULO-1
//   count      out  registered count, always < MODULO
//   at_max     out  count == MODULO-1 (combinational)
//   at_min     out  count == 0 (combinational)
//   wrap       out  pulse: last update wrapped
//   sat        out  pulse: last update blocked at an end
//   load_err   out  pulse: last load was clamped
module updown_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat,
  output logic             load_err
);

  if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
    $error("updown_mod_counter: MODULO out of range");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             load_err_q, load_err_d;

  logic top_q;
  logic bot_q;

  assign top_q = (count_q == MAX_VAL);
  assign bot_q = (count_q == '0);

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    sat_d      = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      // Comparing against MAX_VAL keeps the test in WIDTH bits
      // even when MODULO == 2**WIDTH.
      if (load_value > MAX_VAL) begin
        count_d    = MAX_VAL;
        load_err_d = 1'b1;
      end else begin
        count_d = load_value;
      end
    end else if (en) begin
      if (up) begin
        if (!top_q) begin
          count_d = count_q + 1'b1;
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!bot_q) begin
          count_d = count_q - 1'b1;
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = MAX_VAL;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      sat_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      sat_q      <= sat_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign at_max   = top_q;
  assign at_min   = bot_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: wrap, saturate
// and full-range instances share one stimulus bus.
module tb_updown_mod_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_value = '0;

  logic [2:0] w_count, s_count;
  logic [1:0] f_count;
  logic w_max, w_min, w_wrap, w_sat, w_lerr;
  logic s_max, s_min, s_wrap, s_sat, s_lerr;
  logic f_max, f_min, f_wrap, f_sat, f_lerr;

  int passed = 0;
  int total = 0;

  always #5 clock = ~clock;

  updown_mod_counter #(.WIDTH(3), .MODULO(6), .SATURATE(1'b0)) u_wrap (
    .clock(clock), .reset(reset), .en(en), .up(up),
    .load(load), .load_value(load_value),
    .count(w_count), .at_max(w_max), .at_min(w_min),
    .wrap(w_wrap), .sat(w_sat), .load_err(w_lerr)
  );

  updown_mod_counter #(.WIDTH(3), .MODULO(6), .SATURATE(1'b1)) u_sat (
    .clock(clock), .reset(reset), .en(en), .up(up),
    .load(load), .load_value(load_value),
    .count(s_count), .at_max(s_max), .at_min(s_min),
    .wrap(s_wrap), .sat(s_sat), .load_err(s_lerr)
  );

  updown_mod_counter #(.WIDTH(2), .MODULO(4), .SATURATE(1'b0)) u_full (
    .clock(clock), .reset(reset), .en(en), .up(up),
    .load(load), .load_value(load_value[1:0]),
    .count(f_count), .at_max(f_max), .at_min(f_min),
    .wrap(f_wrap), .sat(f_sat), .load_err(f_lerr)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0;
    step();
    total++;
    if ({w_count, w_wrap, w_sat, w_lerr, w_min} !== 7'b000_0001)
      $display("FAIL reset_wrap got %b exp 0000001",
               {w_count, w_wrap, w_sat, w_lerr, w_min});
    else passed++;
    total++;
    if ({s_count, s_sat, s_lerr} !== 5'b000_00)
      $display("FAIL reset_sat got %b exp 00000",
               {s_count, s_sat, s_lerr});
    else passed++;
  endtask

  task automatic test_up_count();
    int ec[7] = '{1, 2, 3, 4, 5, 0, 1};
    int ew[7] = '{0, 0, 0, 0, 0, 1, 0};
    int em[7] = '{0, 0, 0, 0, 1, 0, 0};
    reset = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      total++;
      if (w_count !== 3'(ec[i]) || w_wrap !== 1'(ew[i])
          || w_max !== 1'(em[i]) || w_sat !== 1'b0)
        $display("FAIL up_count[%0d] got c=%0d w=%b m=%b s=%b exp c=%0d w=%0d m=%0d s=0",
                 i, w_count, w_wrap, w_max, w_sat, ec[i], ew[i], em[i]);
      else passed++;
    end
  endtask

  task automatic test_down_wrap();
    int ec[3] = '{0, 5, 4};
    int ew[3] = '{0, 1, 0};
    int en_[3] = '{1, 0, 0};
    up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (w_count !== 3'(ec[i]) || w_wrap !== 1'(ew[i])
          || w_min !== 1'(en_[i]))
        $display("FAIL down_wrap[%0d] got c=%0d w=%b z=%b exp c=%0d w=%0d z=%0d",
                 i, w_count, w_wrap, w_min, ec[i], ew[i], en_[i]);
      else passed++;
    end
  endtask

  task automatic test_saturate();
    int ec[3] = '{5, 5, 5};
    int es[3] = '{0, 1, 1};
    load = 1'b1; load_value = 3'd4; en = 1'b0;
    step();
    total++;
    if (s_count !== 3'd4)
      $display("FAIL sat_load got %0d exp 4", s_count);
    else passed++;
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (s_count !== 3'(ec[i]) || s_sat !== 1'(es[i])
          || s_wrap !== 1'b0)
        $display("FAIL sat_up[%0d] got c=%0d s=%b w=%b exp c=%0d s=%0d w=0",
                 i, s_count, s_sat, s_wrap, ec[i], es[i]);
      else passed++;
    end
    load = 1'b1; load_value = 3'd0;
    step();
    load = 1'b0; up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (s_count !== 3'd0 || s_sat !== 1'b1 || s_wrap !== 1'b0)
        $display("FAIL sat_down[%0d] got c=%0d s=%b w=%b exp c=0 s=1 w=0",
                 i, s_count, s_sat, s_wrap);
      else passed++;
    end
  endtask

  task automatic test_load();
    load = 1'b1; load_value = 3'd3; en = 1'b1; up = 1'b1;
    step();
    total++;
    if (w_count !== 3'd3 || w_lerr !== 1'b0 || w_wrap !== 1'b0)
      $display("FAIL load_prio got c=%0d e=%b w=%b exp c=3 e=0 w=0",
               w_count, w_lerr, w_wrap);
    else passed++;
    load_value = 3'd7;
    step();
    total++;
    if (w_count !== 3'd5 || w_lerr !== 1'b1)
      $display("FAIL load_clamp got c=%0d e=%b exp c=5 e=1",
               w_count, w_lerr);
    else passed++;
    total++;
    if (s_count !== 3'd5 || s_lerr !== 1'b1)
      $display("FAIL load_clamp_sat got c=%0d e=%b exp c=5 e=1",
               s_count, s_lerr);
    else passed++;
    total++;
    if (f_count !== 2'd3 || f_lerr !== 1'b0)
      $display("FAIL load_full got c=%0d e=%b exp c=3 e=0",
               f_count, f_lerr);
    else passed++;
    load = 1'b0; en = 1'b0;
    step();
    total++;
    if (w_count !== 3'd5 || w_lerr !== 1'b0)
      $display("FAIL load_err_clear got c=%0d e=%b exp c=5 e=0",
               w_count, w_lerr);
    else passed++;
  endtask

  task automatic test_reset_precedence();
    load = 1'b1; load_value = 3'd4;
    step();
    total++;
    if (w_count !== 3'd4)
      $display("FAIL rp_setup got %0d exp 4", w_count);
    else passed++;
    reset = 1'b0; load = 1'b1; load_value = 3'd7; en = 1'b1;
    step();
    total++;
    if ({w_count, w_wrap, w_sat, w_lerr} !== 6'd0
        || {s_count, s_lerr} !== 4'd0)
      $display("FAIL rp_reset got w=%b s=%b exp 0",
               {w_count, w_wrap, w_sat, w_lerr}, {s_count, s_lerr});
    else passed++;
    reset = 1'b1; load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({w_count, w_wrap, w_sat, w_lerr} !== 6'd0)
        $display("FAIL hold[%0d] got %b exp 000000",
                 i, {w_count, w_wrap, w_sat, w_lerr});
      else passed++;
    end
  endtask

  task automatic test_full_range();
    int uc[4] = '{1, 2, 3, 0};
    int uw[4] = '{0, 0, 0, 1};
    int dc[4] = '{3, 2, 1, 0};
    int dw[4] = '{1, 0, 0, 0};
    reset = 1'b0;
    step();
    reset = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (f_count !== 2'(uc[i]) || f_wrap !== 1'(uw[i]))
        $display("FAIL full_up[%0d] got c=%0d w=%b exp c=%0d w=%0d",
                 i, f_count, f_wrap, uc[i], uw[i]);
      else passed++;
    end
    up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (f_count !== 2'(dc[i]) || f_wrap !== 1'(dw[i]))
        $display("FAIL full_down[%0d] got c=%0d w=%b exp c=%0d w=%0d",
                 i, f_count, f_wrap, dc[i], dw[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int ud[4] = '{1, 0, 0, 1};
    int ec[4] = '{1, 0, 5, 0};
    int ew[4] = '{0, 0, 1, 1};
    reset = 1'b0;
    step();
    reset = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = 1'(ud[i]);
      step();
      total++;
      if (w_count !== 3'(ec[i]) || w_wrap !== 1'(ew[i]))
        $display("FAIL b2b[%0d] got c=%0d w=%b exp c=%0d w=%0d",
                 i, w_count, w_wrap, ec[i], ew[i]);
      else passed++;
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_saturate();
    test_load();
    test_reset_precedence();
    test_full_range();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
